// File: rtl/fifo_arbiter_ctrl.sv
// fifo_arbiter_ctrl
//   Shares one FIFO between NREQ producers and a single consumer.
//   Push side: round-robin arbitration with bursts capped at MAXBURST beats.
//   Pop side: valid/ready stream with zero added latency.
//   Also sequences FIFO initialisation and flush, and blocks push-on-full
//   and pop-on-empty, which the FIFO does not guard against.
//
// Ports
//   clk, rst (async, active-low)  clock and reset
//   flush                         synchronous request to empty the FIFO
//   req_valid/req_data/req_ready  producer handshakes (data slice i*WIDTH)
//   fifo_rst/push/data_in/pop     drive the FIFO
//   fifo_full/empty/data_out      FIFO status and read data
//   out_valid/out_data/out_ready  consumer stream
//   grant_id, grant_valid         current arbitration winner
//   level                         tracked occupancy, 0..DEPTH
module fifo_arbiter_ctrl #(
   parameter int WIDTH    = 8,
   parameter int DEPTH    = 8,
   parameter int NREQ     = 4,
   parameter int MAXBURST = 4,
   parameter int IDW      = $clog2(NREQ),
   parameter int LVLW     = $clog2(DEPTH) + 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  flush,
   input  logic [NREQ-1:0]       req_valid,
   input  logic [NREQ*WIDTH-1:0] req_data,
   output logic [NREQ-1:0]       req_ready,
   output logic                  fifo_rst,
   output logic                  fifo_push,
   output logic [WIDTH-1:0]      fifo_data_in,
   output logic                  fifo_pop,
   input  logic                  fifo_full,
   input  logic                  fifo_empty,
   input  logic [WIDTH-1:0]      fifo_data_out,
   output logic                  out_valid,
   output logic [WIDTH-1:0]      out_data,
   input  logic                  out_ready,
   output logic [IDW-1:0]        grant_id,
   output logic                  grant_valid,
   output logic [LVLW-1:0]       level
);

   localparam int unsigned       NR   = NREQ;
   localparam int                BCW  = $clog2(MAXBURST + 1);
   localparam logic [BCW-1:0]    MAXB = BCW'(MAXBURST);
   localparam logic [IDW-1:0]    LAST = IDW'(NREQ - 1);

   typedef enum logic {INIT, RUN} state_t;

   state_t         state;
   logic           lock_valid;
   logic [IDW-1:0] lock_id;
   logic [BCW-1:0] burst_cnt;
   logic [IDW-1:0] rr_ptr;

   logic           run;
   logic           lock_req;
   logic           lock_hold;
   logic           lock_drop;
   logic [IDW-1:0] scan_start;
   logic           scan_found;
   logic [IDW-1:0] scan_id;
   logic [IDW-1:0] grant;
   logic           grant_any;
   logic           push_en;
   logic [BCW-1:0] burst_next;

   function automatic logic [IDW-1:0] next_id(input logic [IDW-1:0] id);
      return (id == LAST) ? '0 : id + 1'b1;
   endfunction

   // Arbitration: a live burst keeps its grant; otherwise scan round-robin.
   // When the locked producer drops out, the scan starts just past it in the
   // same cycle, so the move to the next producer costs no idle cycle.
   always_comb begin
      run      = (state == RUN);
      lock_req = 1'b0;
      for (int unsigned i = 0; i < NR; i++) begin
         if (lock_id == IDW'(i)) lock_req = req_valid[i];
      end
      lock_hold  = lock_valid && lock_req && (burst_cnt < MAXB);
      lock_drop  = lock_valid && !lock_req;
      scan_start = lock_drop ? next_id(lock_id) : rr_ptr;

      scan_found = 1'b0;
      scan_id    = '0;
      for (int unsigned k = 0; k < NR; k++) begin
         int unsigned idx;
         idx = (32'(scan_start) + k) % NR;
         if (!scan_found && req_valid[idx]) begin
            scan_found = 1'b1;
            scan_id    = idx[IDW-1:0];
         end
      end

      grant      = lock_hold ? lock_id : scan_id;
      grant_any  = lock_hold || scan_found;
      burst_next = lock_hold ? burst_cnt + 1'b1 : BCW'(1);
   end

   always_comb begin
      push_en      = run && !flush && grant_any && !fifo_full;
      fifo_push    = push_en;
      req_ready    = '0;
      fifo_data_in = '0;
      for (int unsigned i = 0; i < NR; i++) begin
         if (grant == IDW'(i)) begin
            req_ready[i] = push_en;
            fifo_data_in = req_data[i*WIDTH +: WIDTH];
         end
      end

      out_valid   = run && !flush && !fifo_empty;
      out_data    = fifo_data_out;
      fifo_pop    = out_valid && out_ready;
      fifo_rst    = (state == INIT);
      grant_valid = run && grant_any;
      grant_id    = grant_valid ? grant : '0;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state      <= INIT;
         lock_valid <= 1'b0;
         lock_id    <= '0;
         burst_cnt  <= '0;
         rr_ptr     <= '0;
         level      <= '0;
      end else begin
         case (state)
            INIT: begin
               level      <= '0;
               lock_valid <= 1'b0;
               burst_cnt  <= '0;
               rr_ptr     <= '0;
               state      <= RUN;
            end
            RUN: begin
               if (flush) begin
                  state <= INIT;
               end else begin
                  if (lock_drop) begin
                     lock_valid <= 1'b0;
                     rr_ptr     <= next_id(lock_id);
                  end
                  // A beat overrides the drop bookkeeping above; finishing a
                  // full burst releases the lock and moves the pointer on.
                  if (push_en) begin
                     lock_valid <= 1'b1;
                     lock_id    <= grant;
                     burst_cnt  <= burst_next;
                     if (burst_next == MAXB) begin
                        lock_valid <= 1'b0;
                        rr_ptr     <= next_id(grant);
                     end
                  end
                  if (push_en && !fifo_pop)      level <= level + 1'b1;
                  else if (fifo_pop && !push_en) level <= level - 1'b1;
               end
            end
            default: state <= INIT;
         endcase
      end
   end

endmodule

// File: tb/tb_fifo_arbiter_ctrl.sv
module tb_fifo_arbiter_ctrl;

   localparam int WIDTH = 8;
   localparam int DEPTH = 8;
   localparam int NREQ  = 4;
   localparam int IDW   = 2;
   localparam int LVLW  = 4;

   logic                  clk = 1'b0;
   logic                  rst;
   logic                  flush;
   logic [NREQ-1:0]       req_valid;
   logic [NREQ*WIDTH-1:0] req_data;
   logic [NREQ-1:0]       req_ready;
   logic                  fifo_rst, fifo_push, fifo_pop;
   logic [WIDTH-1:0]      fifo_data_in;
   logic                  fifo_full, fifo_empty;
   logic [WIDTH-1:0]      fifo_data_out;
   logic                  out_valid;
   logic [WIDTH-1:0]      out_data;
   logic                  out_ready;
   logic [IDW-1:0]        grant_id;
   logic                  grant_valid;
   logic [LVLW-1:0]       level;

   int vectors = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   fifo_arbiter_ctrl #(.WIDTH(WIDTH), .DEPTH(DEPTH), .NREQ(NREQ), .MAXBURST(4)) dut (
      .clk(clk), .rst(rst), .flush(flush),
      .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
      .fifo_rst(fifo_rst), .fifo_push(fifo_push), .fifo_data_in(fifo_data_in),
      .fifo_pop(fifo_pop), .fifo_full(fifo_full), .fifo_empty(fifo_empty),
      .fifo_data_out(fifo_data_out), .out_valid(out_valid), .out_data(out_data),
      .out_ready(out_ready), .grant_id(grant_id), .grant_valid(grant_valid),
      .level(level)
   );

   // Behavioural FIFO: pointer-based full/empty, synchronous active-high reset,
   // read data visible combinationally at the head.
   logic [WIDTH-1:0] mem [DEPTH];
   logic [3:0]       wptr, rptr;

   always @(posedge clk) begin
      if (fifo_rst) begin
         wptr <= '0;
         rptr <= '0;
      end else begin
         if (fifo_push) begin
            mem[wptr[2:0]] <= fifo_data_in;
            wptr <= wptr + 4'd1;
         end
         if (fifo_pop) rptr <= rptr + 4'd1;
      end
   end

   assign fifo_full     = (wptr[3] != rptr[3]) && (wptr[2:0] == rptr[2:0]);
   assign fifo_empty    = (wptr == rptr);
   assign fifo_data_out = mem[rptr[2:0]];

   task automatic restart();
      @(negedge clk);
      rst = 1'b0; flush = 1'b0; req_valid = '0; out_ready = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
   endtask

   task automatic test_reset();
      rst = 1'b0; flush = 1'b0; req_valid = 4'b0001; req_data = '0; out_ready = 1'b1;
      @(negedge clk); @(negedge clk); #1;
      vectors++; if (fifo_rst !== 1'b1) begin miscompares++; $display("FAIL rst_fifo_rst got %b exp 1", fifo_rst); end
      vectors++; if (level !== 4'd0) begin miscompares++; $display("FAIL rst_level got %0d exp 0", level); end
      vectors++; if (req_ready !== 4'b0000) begin miscompares++; $display("FAIL rst_req_ready got %b exp 0000", req_ready); end
      vectors++; if ({fifo_push, fifo_pop, out_valid, grant_valid} !== 4'b0000) begin miscompares++; $display("FAIL rst_ctrl got %b exp 0000", {fifo_push, fifo_pop, out_valid, grant_valid}); end
      @(negedge clk); rst = 1'b1; #1;
      vectors++; if (fifo_rst !== 1'b1) begin miscompares++; $display("FAIL init_fifo_rst got %b exp 1", fifo_rst); end
      vectors++; if ({req_ready, fifo_push, out_valid} !== 6'b0) begin miscompares++; $display("FAIL init_ctrl got %b exp 000000", {req_ready, fifo_push, out_valid}); end
      @(negedge clk); req_valid = '0; out_ready = 1'b0; #1;
      vectors++; if (fifo_rst !== 1'b0) begin miscompares++; $display("FAIL run_fifo_rst got %b exp 0", fifo_rst); end
      vectors++; if (level !== 4'd0 || out_valid !== 1'b0) begin miscompares++; $display("FAIL run_idle got level=%0d ov=%b exp level=0 ov=0", level, out_valid); end
   endtask

   task automatic test_fill_drain();
      int nxt = 1;
      restart();
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         req_valid = {3'b000, (nxt <= 10)}; req_data[7:0] = 8'(nxt); #1;
         vectors++;
         if (req_ready !== ((c < 8) ? 4'b0001 : 4'b0000)) begin miscompares++; $display("FAIL fill_ready c=%0d got %b exp %b", c, req_ready, (c < 8) ? 4'b0001 : 4'b0000); end
         if (req_ready[0]) nxt++;
      end
      vectors++; if (fifo_full !== 1'b1 || level !== 4'd8) begin miscompares++; $display("FAIL fill_full got full=%b level=%0d exp full=1 level=8", fifo_full, level); end
      for (int c = 0; c <= 10; c++) begin
         logic [3:0] exp_lvl;
         logic       exp_push;
         exp_lvl  = (c == 0) ? 4'd8 : ((c <= 3) ? 4'd7 : 4'(10 - c));
         exp_push = (c == 1) || (c == 2);
         @(negedge clk);
         out_ready = 1'b1;
         req_valid = {3'b000, (nxt <= 10)}; req_data[7:0] = 8'(nxt); #1;
         vectors++; if (level !== exp_lvl) begin miscompares++; $display("FAIL drain_level c=%0d got %0d exp %0d", c, level, exp_lvl); end
         vectors++; if (fifo_push !== exp_push) begin miscompares++; $display("FAIL drain_push c=%0d got %b exp %b", c, fifo_push, exp_push); end
         if (c == 0) begin
            vectors++; if (fifo_pop !== 1'b1 || fifo_full !== 1'b1) begin miscompares++; $display("FAIL full_pop_only got pop=%b full=%b exp pop=1 full=1", fifo_pop, fifo_full); end
         end
         if (c < 10) begin
            vectors++; if (out_valid !== 1'b1 || fifo_pop !== 1'b1 || out_data !== 8'(c + 1)) begin miscompares++; $display("FAIL drain_data c=%0d got v=%b pop=%b d=%h exp v=1 pop=1 d=%h", c, out_valid, fifo_pop, out_data, 8'(c + 1)); end
         end else begin
            vectors++; if (out_valid !== 1'b0 || fifo_pop !== 1'b0) begin miscompares++; $display("FAIL drain_empty got v=%b pop=%b exp 0 0", out_valid, fifo_pop); end
         end
         if (req_ready[0]) nxt++;
      end
   endtask

   task automatic test_round_robin();
      restart();
      req_data = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
      for (int c = 0; c < 16; c++) begin
         int g;
         g = (c / 4) % 3;
         @(negedge clk);
         req_valid = 4'b0111; out_ready = 1'b1; #1;
         vectors++; if (grant_id !== 2'(g) || grant_valid !== 1'b1 || req_ready !== 4'(1 << g) || fifo_push !== 1'b1) begin miscompares++; $display("FAIL rr_grant c=%0d got id=%0d gv=%b rdy=%b push=%b exp id=%0d", c, grant_id, grant_valid, req_ready, fifo_push, g); end
         vectors++; if (out_valid !== (c > 0)) begin miscompares++; $display("FAIL rr_valid c=%0d got %b exp %b", c, out_valid, c > 0); end
         if (c > 0) begin
            vectors++; if (out_data !== 8'(8'hA0 + ((c - 1) / 4) % 3)) begin miscompares++; $display("FAIL rr_data c=%0d got %h exp %h", c, out_data, 8'(8'hA0 + ((c - 1) / 4) % 3)); end
         end
      end
   endtask

   task automatic test_drop_requeue();
      int exp_g [11] = '{1, 1, 2, 2, 2, 2, 0, 0, 0, 0, 1};
      int prev = 0;
      for (int c = 0; c < 11; c++) begin
         @(negedge clk);
         req_valid = (c == 2) ? 4'b0101 : 4'b0111; #1;
         vectors++; if (grant_id !== 2'(exp_g[c]) || req_ready !== 4'(1 << exp_g[c])) begin miscompares++; $display("FAIL drop_grant c=%0d got id=%0d rdy=%b exp id=%0d", c, grant_id, req_ready, exp_g[c]); end
         vectors++; if (out_data !== 8'(8'hA0 + prev)) begin miscompares++; $display("FAIL drop_data c=%0d got %h exp %h", c, out_data, 8'(8'hA0 + prev)); end
         prev = exp_g[c];
      end
   endtask

   task automatic test_flush();
      int exp_g [5] = '{1, 1, 1, 1, 2};
      restart();
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         req_valid = 4'b0110; out_ready = 1'b0; #1;
         vectors++; if (grant_id !== 2'(exp_g[c]) || fifo_push !== 1'b1) begin miscompares++; $display("FAIL fl_fill c=%0d got id=%0d push=%b exp id=%0d push=1", c, grant_id, fifo_push, exp_g[c]); end
      end
      @(negedge clk); flush = 1'b1; #1;
      vectors++; if (level !== 4'd5) begin miscompares++; $display("FAIL fl_level5 got %0d exp 5", level); end
      vectors++; if ({fifo_push, fifo_pop, out_valid, req_ready} !== 7'b0) begin miscompares++; $display("FAIL fl_block got %b exp 0000000", {fifo_push, fifo_pop, out_valid, req_ready}); end
      @(negedge clk); flush = 1'b0; #1;
      vectors++; if (fifo_rst !== 1'b1 || req_ready !== 4'b0000 || out_valid !== 1'b0) begin miscompares++; $display("FAIL fl_init got frst=%b rdy=%b ov=%b exp 1 0000 0", fifo_rst, req_ready, out_valid); end
      @(negedge clk); req_valid = 4'b0111; #1;
      vectors++; if (fifo_rst !== 1'b0 || level !== 4'd0 || out_valid !== 1'b0) begin miscompares++; $display("FAIL fl_clear got frst=%b level=%0d ov=%b exp 0 0 0", fifo_rst, level, out_valid); end
      vectors++; if (grant_id !== 2'd0 || req_ready !== 4'b0001) begin miscompares++; $display("FAIL fl_regrant got id=%0d rdy=%b exp 0 0001", grant_id, req_ready); end
   endtask

   task automatic test_async_reset();
      @(negedge clk); #1;
      vectors++; if (level !== 4'd1) begin miscompares++; $display("FAIL ar_pre_level got %0d exp 1", level); end
      #2 rst = 1'b0; #1;
      vectors++; if (level !== 4'd0 || fifo_rst !== 1'b1 || grant_valid !== 1'b0 || req_ready !== 4'b0000) begin miscompares++; $display("FAIL ar_clear got level=%0d frst=%b gv=%b rdy=%b exp 0 1 0 0000", level, fifo_rst, grant_valid, req_ready); end
      @(negedge clk); rst = 1'b1; #1;
      vectors++; if (fifo_rst !== 1'b1) begin miscompares++; $display("FAIL ar_init got %b exp 1", fifo_rst); end
      @(negedge clk); #1;
      vectors++; if (fifo_rst !== 1'b0 || req_ready !== 4'b0001) begin miscompares++; $display("FAIL ar_run got frst=%b rdy=%b exp 0 0001", fifo_rst, req_ready); end
   endtask

   initial begin
      test_reset();
      test_fill_drain();
      test_round_robin();
      test_drop_requeue();
      test_flush();
      test_async_reset();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
